// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub
//   Pipelined adder/subtractor. The WIDTH-bit carry chain is cut into STAGES slices of
//   SW = WIDTH/STAGES bits. Stage k adds slice k and registers it. The upper operand slices
//   that are still unprocessed, the finished lower sum slices and the slice carry all move
//   down the pipe together with a per-stage valid bit. The last stage also registers the
//   overflow and zero flags, so every result output comes straight from a flop.
//
//   A stalled output (out_valid && !out_ready) freezes the whole pipe. While it is frozen,
//   in_ready is low.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      operand beat present
//   in_ready   out  1      beat accepted this cycle (combinational: !stall)
//   a, b       in   WIDTH  operands
//   carry_in   in   1      carry into bit 0 (add mode only)
//   subtract   in   1      0: a+b+carry_in, 1: a-b (carry_in ignored)
//   out_valid  out  1      result beat present
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   carry_out  out  1      carry out of MSB (subtract: 1 = no borrow)
//   overflow   out  1      signed overflow
//   zero       out  1      sum == 0

module pipelined_add_sub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             subtract,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned SW   = WIDTH / STAGES;
  localparam int unsigned Last = STAGES - 1;

  // Stage registers: valid bit, operand A, pre-inverted operand B', partial sum, slice carry.
  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic              ovf_q;
  logic              zero_q;

  // Inputs seen by each stage: the ports for stage 0, the previous register otherwise.
  logic [STAGES-1:0] p_v;
  logic [WIDTH-1:0]  p_a [STAGES];
  logic [WIDTH-1:0]  p_b [STAGES];
  logic [WIDTH-1:0]  p_s [STAGES];
  logic [STAGES-1:0] p_c;

  // Results each stage produces for its register.
  logic [WIDTH-1:0]  nxt_s [STAGES];
  logic [STAGES-1:0] nxt_c;
  logic              ovf_d;
  logic              zero_d;
  logic              msb_cin;

  logic stall;

  assign stall    = vld_q[Last] && !out_ready;
  assign in_ready = !stall;

  // Stage input routing. Subtraction becomes a + ~b + 1 at the pipe entry, and the mode is
  // not needed after that point. This lets beats with different modes follow each other
  // without interfering.
  always_comb begin
    p_v    = '0;
    p_c    = '0;
    p_v[0] = in_valid;
    p_a[0] = a;
    p_b[0] = subtract ? ~b : b;
    p_s[0] = '0;
    p_c[0] = subtract ? 1'b1 : carry_in;
    for (int k = 1; k < STAGES; k++) begin
      p_v[k] = vld_q[k-1];
      p_a[k] = a_q[k-1];
      p_b[k] = b_q[k-1];
      p_s[k] = s_q[k-1];
      p_c[k] = c_q[k-1];
    end
  end

  // One SW-bit slice of the carry chain per stage.
  always_comb begin
    logic [SW:0] slice_sum;
    slice_sum = '0;
    nxt_c     = '0;
    for (int k = 0; k < STAGES; k++) begin
      slice_sum = {1'b0, p_a[k][k*SW +: SW]} + {1'b0, p_b[k][k*SW +: SW]}
                + {{SW{1'b0}}, p_c[k]};
      nxt_s[k]              = p_s[k];
      nxt_s[k][k*SW +: SW]  = slice_sum[SW-1:0];
      nxt_c[k]              = slice_sum[SW];
    end
  end

  // The carry into the MSB is recovered from the MSB's own sum bit:
  // s = a ^ b' ^ cin, so cin = a ^ b' ^ s.
  always_comb begin
    msb_cin = p_a[Last][WIDTH-1] ^ p_b[Last][WIDTH-1] ^ nxt_s[Last][WIDTH-1];
    ovf_d   = msb_cin ^ nxt_c[Last];
    zero_d  = (nxt_s[Last] == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (!stall) begin
      vld_q  <= p_v;
      c_q    <= nxt_c;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= p_a[k];
        b_q[k] <= p_b[k];
        s_q[k] <= nxt_s[k];
      end
    end
  end

  assign out_valid = vld_q[Last];
  assign sum       = s_q[Last];
  assign carry_out = c_q[Last];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub. The design is instantiated three times on shared inputs:
// 32/4 (main), 32/1 (single registered adder) and 8/8 (1-bit slices).
// A negedge monitor keeps one expected-result ring per instance. Each expected result is
// computed with plain wide arithmetic.

module tb_pipelined_add_sub;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        carry_in = 1'b0;
  logic        subtract = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic [2:0]  ir, ovd, co, ovf, zr;
  logic [31:0] s0, s1;
  logic [7:0]  s2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
    .carry_in(carry_in), .subtract(subtract), .out_valid(ovd[0]), .out_ready(out_ready),
    .sum(s0), .carry_out(co[0]), .overflow(ovf[0]), .zero(zr[0])
  );

  pipelined_add_sub #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
    .carry_in(carry_in), .subtract(subtract), .out_valid(ovd[1]), .out_ready(out_ready),
    .sum(s1), .carry_out(co[1]), .overflow(ovf[1]), .zero(zr[1])
  );

  pipelined_add_sub #(.WIDTH(8), .STAGES(8)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .a(a[7:0]),
    .b(b[7:0]), .carry_in(carry_in), .subtract(subtract), .out_valid(ovd[2]),
    .out_ready(out_ready), .sum(s2), .carry_out(co[2]), .overflow(ovf[2]), .zero(zr[2])
  );

  // Reference: {zero, overflow, carry_out, sum} for a w-bit add/sub.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic sub, input int w);
    longint unsigned mask, xv, yv, full;
    logic c, v, z;
    mask = (64'd1 << w) - 64'd1;
    xv   = {32'd0, x} & mask;
    yv   = {32'd0, y};
    yv   = sub ? (~yv & mask) : (yv & mask);
    full = xv + yv + (sub ? 64'd1 : {63'd0, ci});
    c    = full[w];
    // Signed overflow: both addends share a sign that the result does not.
    v    = (xv[w-1] == yv[w-1]) && (full[w-1] != xv[w-1]);
    z    = ((full & mask) == 64'd0);
    return {z, v, c, 32'(full & mask)};
  endfunction

  function automatic logic [31:0] sum_of(input int d);
    case (d)
      0:       return s0;
      1:       return s1;
      default: return {24'd0, s2};
    endcase
  endfunction

  function automatic int width_of(input int d);
    return (d == 2) ? 8 : 32;
  endfunction

  // Scoreboard monitor.
  logic [34:0] exp_mem [3][64];
  int          wr [3] = '{0, 0, 0};
  int          rd [3] = '{0, 0, 0};
  logic        prev_stall [3] = '{1'b0, 1'b0, 1'b0};
  logic [34:0] prev_out [3];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      logic [34:0] got;
      got = {zr[d], ovf[d], co[d], sum_of(d)};
      if (reset) begin
        rd[d]         = wr[d];
        prev_stall[d] = 1'b0;
      end else begin
        n_tests++;
        if (ir[d] !== !(ovd[d] && !out_ready)) begin
          n_fail++;
          $display("FAIL in_ready dut%0d: got %b expected %b", d, ir[d],
                   !(ovd[d] && !out_ready));
        end
        if (prev_stall[d]) begin
          n_tests++;
          if (ovd[d] !== 1'b1 || got !== prev_out[d]) begin
            n_fail++;
            $display("FAIL stall_hold dut%0d: got v=%b %h expected v=1 %h", d, ovd[d], got,
                     prev_out[d]);
          end
        end
        if (ovd[d] && out_ready) begin
          n_tests++;
          if (rd[d] == wr[d]) begin
            n_fail++;
            $display("FAIL extra_beat dut%0d: got %h expected no beat", d, got);
          end else begin
            if (got !== exp_mem[d][rd[d] % 64]) begin
              n_fail++;
              $display("FAIL result dut%0d: got %h expected %h", d, got,
                       exp_mem[d][rd[d] % 64]);
            end
            rd[d]++;
          end
        end
        if (in_valid && ir[d]) begin
          exp_mem[d][wr[d] % 64] = model(a, b, carry_in, subtract, width_of(d));
          wr[d]++;
        end
        prev_stall[d] = ovd[d] && !out_ready;
        prev_out[d]   = got;
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one beat on an empty pipe. Return dut d's first result and the number of edges,
  // counting the accepting edge, until out_valid rises.
  task automatic run_beat(input int d, input logic [31:0] ai, input logic [31:0] bi,
                          input logic ci, input logic sub, output logic [34:0] got,
                          output int lat);
    idle(10);
    a = ai; b = bi; carry_in = ci; subtract = sub; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!ovd[d] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = {zr[d], ovf[d], co[d], sum_of(d)};
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; a = 32'd1; b = 32'd1; carry_in = 1'b0; subtract = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if ({ovd[d], co[d], ovf[d], zr[d]} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_flags dut%0d: got %b expected 0000", d,
                 {ovd[d], co[d], ovf[d], zr[d]});
      end
      n_tests++;
      if (sum_of(d) !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_sum dut%0d: got %h expected 0", d, sum_of(d));
      end
      n_tests++;
      if (ir[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_in_ready dut%0d: got %b expected 1", d, ir[d]);
      end
    end
    // The beat presented during reset must never come out.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (ovd !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_no_beat: got %b expected 000", ovd);
      end
    end
  endtask

  task automatic test_single();
    logic [34:0] got;
    int          lat;
    run_beat(0, 32'd1, 32'd1, 1'b0, 1'b0, got, lat);
    n_tests++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL latency_s4: got %0d expected 4", lat);
    end
    n_tests++;
    if (got !== {1'b0, 1'b0, 1'b0, 32'd2}) begin
      n_fail++;
      $display("FAIL single_s4: got %h expected %h", got, {1'b0, 1'b0, 1'b0, 32'd2});
    end
    run_beat(1, 32'd1, 32'd1, 1'b0, 1'b0, got, lat);
    n_tests++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL latency_s1: got %0d expected 1", lat);
    end
    n_tests++;
    if (got !== {1'b0, 1'b0, 1'b0, 32'd2}) begin
      n_fail++;
      $display("FAIL single_s1: got %h expected %h", got, {1'b0, 1'b0, 1'b0, 32'd2});
    end
  endtask

  task automatic test_add_edges();
    logic [31:0] ta [2] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] tb [2] = '{32'h0000_0001, 32'h0000_0001};
    logic        tc [2] = '{1'b1, 1'b0};
    logic [34:0] te [2] = '{{1'b0, 1'b0, 1'b1, 32'h0000_0001},
                            {1'b0, 1'b1, 1'b0, 32'h8000_0000}};
    logic [34:0] got;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      run_beat(0, ta[i], tb[i], tc[i], 1'b0, got, lat);
      n_tests++;
      if (got !== te[i]) begin
        n_fail++;
        $display("FAIL add_edge%0d: got %h expected %h (lat %0d)", i, got, te[i], lat);
      end
    end
  endtask

  task automatic test_sub_edges();
    logic [31:0] ta [3] = '{32'd5, 32'd3, 32'h8000_0000};
    logic [31:0] tb [3] = '{32'd5, 32'd5, 32'd1};
    logic        tc [3] = '{1'b0, 1'b1, 1'b0};
    logic [34:0] te [3] = '{{1'b1, 1'b0, 1'b1, 32'h0000_0000},
                            {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE},
                            {1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF}};
    logic [34:0] got;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      run_beat(0, ta[i], tb[i], tc[i], 1'b1, got, lat);
      n_tests++;
      if (got !== te[i]) begin
        n_fail++;
        $display("FAIL sub_edge%0d: got %h expected %h (lat %0d)", i, got, te[i], lat);
      end
    end
  endtask

  task automatic test_narrow();
    logic [34:0] got;
    int          lat;
    run_beat(2, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, got, lat);
    n_tests++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL latency_w8s8: got %0d expected 8", lat);
    end
    n_tests++;
    if (got !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL narrow_ff_01: got %h expected %h", got, {1'b1, 1'b0, 1'b1, 32'h0});
    end
  endtask

  task automatic test_back_to_back();
    logic [34:0] exp_b [10];
    logic [34:0] got;
    logic        want_v;
    idle(10);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc < 10) begin
        in_valid = 1'b1;
        a        = 32'hAAAA_AAAA;
        b        = 32'h5555_5555;
        carry_in = cyc[0];
        subtract = cyc[1];
        exp_b[cyc] = model(a, b, carry_in, subtract, 32);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      want_v = (cyc >= 4) && (cyc < 14);
      n_tests++;
      if (ovd[0] !== want_v) begin
        n_fail++;
        $display("FAIL b2b_valid cyc%0d: got %b expected %b", cyc, ovd[0], want_v);
      end
      if (want_v) begin
        got = {zr[0], ovf[0], co[0], s0};
        n_tests++;
        if (got !== exp_b[cyc-4]) begin
          n_fail++;
          $display("FAIL b2b_data beat%0d: got %h expected %h", cyc - 4, got, exp_b[cyc-4]);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    logic [34:0] held;
    logic [34:0] got;
    idle(10);
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid  = 1'b1;
      a         = $urandom;
      b         = $urandom;
      carry_in  = 1'($urandom);
      subtract  = 1'($urandom);
      out_ready = !(cyc >= 8 && cyc <= 10);
      #1;
      got = {zr[0], ovf[0], co[0], s0};
      if (!out_ready) begin
        n_tests++;
        if (ir[0] !== 1'b0 || ovd[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_stall cyc%0d: got ir=%b ov=%b expected ir=0 ov=1", cyc, ir[0],
                   ovd[0]);
        end
        if (cyc == 8) held = got;
        else begin
          n_tests++;
          if (got !== held) begin
            n_fail++;
            $display("FAIL bp_hold cyc%0d: got %h expected %h", cyc, got, held);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    // Reset with beats in flight in every instance.
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; a = $urandom; b = $urandom;
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      n_tests++;
      if (ovd !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_flush cyc%0d: got %b expected 000", i, ovd);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    logic [31:0] corner [5] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 10) < 7;
      a         = ($urandom % 3 == 0) ? corner[$urandom % 5] : $urandom;
      b         = ($urandom % 3 == 0) ? corner[$urandom % 5] : $urandom;
      carry_in  = 1'($urandom);
      subtract  = 1'($urandom);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle(12);
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (rd[d] != wr[d]) begin
        n_fail++;
        $display("FAIL drain dut%0d: got %0d beats out expected %0d", d, rd[d], wr[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_add_edges();
    test_sub_edges();
    test_narrow();
    test_back_to_back();
    test_backpressure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
